// File: rtl/zbb_seq.sv
// zbb_seq: multi-cycle Zbb helper (serial CLZ/CTZ/CPOP, 1-bit/cycle ROL/ROR).
// Optional feature macro: ZBB_SEQ_EARLY_EXIT_EN (CLZ/CTZ leave RUN on first one found).
module zbb_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] din_rs1_i,
  input  logic [XLEN-1:0] din_rs2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] dout_rd_o,
  output logic            busy_o
);
  localparam int LW = $clog2(XLEN);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] NSCAN = CW'(XLEN / STEP);

  localparam logic [2:0] OP_CLZ  = 3'd0;
  localparam logic [2:0] OP_CTZ  = 3'd1;
  localparam logic [2:0] OP_CPOP = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found_q, found_d;
  logic [XLEN-1:0] dout_q, dout_d;

  // Only the low log2(XLEN) bits of the rotate amount matter.
  logic unused_rs2;
  assign unused_rs2 = ^din_rs2_i[XLEN-1:LW];

  logic [STEP-1:0] hi_c, lo_c;
  logic [CW-1:0]   lz_c, tz_c, pc_c;
  logic            done_c;

  // Chunk statistics: leading zeros of the top chunk, trailing zeros/popcount of the bottom chunk.
  always_comb begin
    hi_c = work_q[XLEN-1 -: STEP];
    lo_c = work_q[STEP-1:0];
    lz_c = CW'(STEP);
    tz_c = CW'(STEP);
    pc_c = '0;
    for (int i = 0; i < STEP; i++) begin
      if (hi_c[i]) lz_c = CW'(STEP - 1 - i);
      pc_c = pc_c + CW'(lo_c[i]);
    end
    for (int i = STEP - 1; i >= 0; i--) begin
      if (lo_c[i]) tz_c = CW'(i);
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    dout_d  = dout_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        // flush wins over a request arriving in the same cycle
        if (req_valid_i && !flush_i) begin
          op_d    = req_op_i;
          work_d  = din_rs1_i;
          acc_d   = '0;
          found_d = 1'b0;
          case (req_op_i)
            OP_CLZ, OP_CTZ, OP_CPOP: cnt_d = NSCAN;
            OP_ROL, OP_ROR:          cnt_d = {1'b0, din_rs2_i[LW-1:0]};
            default:                 cnt_d = '0;
          endcase
          if (cnt_d == '0) begin
            state_d = DONE;
            dout_d  = (req_op_i == OP_ROL || req_op_i == OP_ROR) ? din_rs1_i : '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          done_c = (cnt_d == '0);
          case (op_q)
            OP_CLZ: begin
              work_d = work_q << STEP;
              if (!found_q) begin
                acc_d   = acc_q + lz_c;
                found_d = |hi_c;
              end
`ifdef ZBB_SEQ_EARLY_EXIT_EN
              if (|hi_c) done_c = 1'b1;
`endif
            end
            OP_CTZ: begin
              work_d = work_q >> STEP;
              if (!found_q) begin
                acc_d   = acc_q + tz_c;
                found_d = |lo_c;
              end
`ifdef ZBB_SEQ_EARLY_EXIT_EN
              if (|lo_c) done_c = 1'b1;
`endif
            end
            OP_CPOP: begin
              work_d = work_q >> STEP;
              acc_d  = acc_q + pc_c;
            end
            OP_ROL:  work_d = {work_q[XLEN-2:0], work_q[XLEN-1]};
            OP_ROR:  work_d = {work_q[0], work_q[XLEN-1:1]};
            default: done_c = 1'b1;
          endcase
          if (done_c) begin
            state_d = DONE;
            if (op_q == OP_ROL || op_q == OP_ROR) dout_d = work_d;
            else if (op_q <= OP_CPOP)              dout_d = {{(XLEN-CW){1'b0}}, acc_d};
            else                                   dout_d = '0;
          end
        end
      end
      DONE: begin
        if (flush_i || resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      dout_q  <= dout_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign dout_rd_o    = dout_q;
endmodule

// File: tb/tb_zbb_seq.sv
// tb_zbb_seq: table vectors, random ops vs. a reference model, and handshake/abort sequences.
module tb_zbb_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] dout_rd;
  logic        busy;

  int n_pass = 0, n_total = 0;

  zbb_seq #(.XLEN(32), .STEP(1)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .din_rs1_i(rs1), .din_rs2_i(rs2), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .dout_rd_o(dout_rd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: operate on the spec's bit-level definitions directly.
  function automatic int ref_clz(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction
  function automatic int ref_ctz(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return i;
    return 32;
  endfunction
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = b % 32;
    case (op)
      3'd0: return 32'(ref_clz(a));
      3'd1: return 32'(ref_ctz(a));
      3'd2: return 32'($countones(a));
      3'd3: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'd4: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: return 32'd0;
    endcase
  endfunction
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
`ifdef ZBB_SEQ_EARLY_EXIT_EN
      3'd0: return (a == 0) ? 33 : ref_clz(a) + 2;
      3'd1: return (a == 0) ? 33 : ref_ctz(a) + 2;
`else
      3'd0, 3'd1: return 33;
`endif
      3'd2: return 33;
      3'd3, 3'd4: return (b % 32) + 1;
      default: return 1;
    endcase
  endfunction

  // Issue one op (caller is just after an edge, unit IDLE); returns latency and result.
  // Latency counts edges from the accept edge inclusive up to the one after which resp_valid is seen.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = dout_rd;
  endtask

  // Complete the handshake of a pending response (resp_ready assumed high).
  task automatic retire();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  initial begin
    vec_t vt[$];
    int lat, cnt;
    logic [31:0] res, held;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vt.push_back('{3'd0, 32'h00010000, 32'h0, 32'd15, 33, "clz_0x10000"});
    vt.push_back('{3'd1, 32'h00000000, 32'h0, 32'd32, 33, "ctz_zero"});
    vt.push_back('{3'd2, 32'hF0F00001, 32'h0, 32'd9,  33, "cpop_f0f00001"});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'h0, 32'd32, 33, "cpop_ones"});
    vt.push_back('{3'd4, 32'h80000001, 32'd4, 32'h18000000, 5, "ror_4"});
    vt.push_back('{3'd3, 32'h80000001, 32'd36, 32'h00000018, 5, "rol_36"});
    vt.push_back('{3'd3, 32'h12345678, 32'd0, 32'h12345678, 1, "rol_0"});
    vt.push_back('{3'd6, 32'hDEADBEEF, 32'd7, 32'h0, 1, "reserved_6"});
    vt.push_back('{3'd0, 32'h00000000, 32'h0, 32'd32, 33, "clz_zero"});
    vt.push_back('{3'd0, 32'h80000000, 32'h0, 32'd0, 33, "clz_msb"});
    vt.push_back('{3'd4, 32'h00000001, 32'd31, 32'h00000002, 32, "ror_31"});
`ifdef ZBB_SEQ_EARLY_EXIT_EN
    vt[0].lat = 17;
    vt[9].lat = 2;
`endif

    // Reset state
    #2;
    chk("reset_outputs", {28'd0, req_ready, resp_valid, busy, 1'b0} | dout_rd, 32'h8);
    chk("reset_dout", dout_rd, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, lat, res);
      chk({vt[i].name, "_res"}, res, vt[i].exp);
      chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
      retire();
    end

    // Random ops against the reference model
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: ra = ra & 32'h000000FF;
        1: ra = 32'h1 << $urandom_range(0, 31);
        default: ;
      endcase
      rb = $urandom;
      issue(rop, ra, rb, lat, res);
      chk($sformatf("rand%0d_op%0d_res", k, rop), res, ref_res(rop, ra, rb));
      chk($sformatf("rand%0d_op%0d_lat", k, rop), 32'(lat), 32'(ref_lat(rop, ra, rb)));
      retire();
    end

    // Backpressure: response held, req_valid during DONE ignored
    resp_ready = 1'b0;
    issue(3'd4, 32'h0000000F, 32'd2, lat, res);
    chk("bp_res", res, 32'hC0000003);
    held = res;
    req_valid = 1'b1; req_op = 3'd6; rs1 = 32'h5; rs2 = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_ctl", c), {30'd0, resp_valid, req_ready}, 32'h2);
      chk($sformatf("bp_hold%0d_dout", c), dout_rd, held);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ctl", {29'd0, req_ready, resp_valid, busy}, 32'h4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_late_accept", {30'd0, resp_valid, busy}, 32'h3);
    chk("bp_late_res", dout_rd, 32'h0);
    retire();

    // Flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd3; rs1 = 32'hA5A5A5A5; rs2 = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle_block", {31'd0, busy}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("flush_idle_then_accept", {30'd0, resp_valid, busy}, 32'h3);
    chk("flush_idle_then_res", dout_rd, 32'hA5A5A5A5);
    retire();

    // Flush at RUN cycle 10
    req_valid = 1'b1; req_op = 3'd0; rs1 = 32'h0; rs2 = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_run_ctl", {29'd0, req_ready, resp_valid, busy}, 32'h4);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) cnt++;
    end
    chk("flush_run_no_resp", 32'(cnt), 32'd0);

    // Async reset mid-RUN (dout made nonzero first)
    issue(3'd3, 32'h12345678, 32'd0, lat, res);
    retire();
    req_valid = 1'b1; req_op = 3'd1; rs1 = 32'h0; rs2 = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'd0, req_ready, resp_valid, busy}, 32'h4);
    chk("rst_mid_dout", dout_rd, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'd1, 32'h00000008, 32'h0, lat, res);
    chk("post_rst_ctz8_res", res, 32'd3);
    chk("post_rst_ctz8_lat", 32'(lat), 32'(ref_lat(3'd1, 32'h8, 32'h0)));
    retire();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
